// File: rtl/z80_io_responder_pkg.sv
// rtl/z80_io_responder_pkg.sv - shared bus definitions for the Z80 I/O responder
// Purpose: FSM state encoding, Z80 pin-active levels and small helpers
//          (register slice position, IM2 vector shaping, port-byte extraction).
// Ports: none (package).
package z80_io_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACT  = 2'd2,
    ST_INTA = 2'd3
  } state_t;

  // Z80 control pins are active low.
  localparam logic PIN_ON  = 1'b0;
  localparam logic PIN_OFF = 1'b1;

  // Bit position of register i inside the flattened reg_q bus.
  function automatic int reg_lsb(input int i);
    return 8 * i;
  endfunction

  // IM2 vectors must be even; bit 0 is always driven low.
  function automatic logic [7:0] inta_vector(input logic [7:0] vec);
    return {vec[7:1], 1'b0};
  endfunction

  // I/O cycles only decode the low address byte; the high byte carries
  // the accumulator or B register and is ignored.
  function automatic logic [7:0] port_of(input logic [15:0] addr);
    return addr[7:0];
  endfunction

endpackage

// File: rtl/z80_io_responder_wait_timer.sv
// rtl/z80_io_responder_wait_timer.sv - 4-bit load/decrement wait-state counter
// Purpose: counts the remaining wait cycles of a matched I/O cycle; o_done
//          marks the last wait cycle so the FSM can release nWAIT.
// Ports:
//   clk         in  1  CPU clock
//   nRESET      in  1  synchronous active-low reset
//   i_load      in  1  load i_load_val (takes priority over i_dec)
//   i_load_val  in  4  wait-state count to load
//   i_dec       in  1  decrement by one (saturates at zero)
//   o_done      out 1  counter is at 1: this edge ends the wait
module z80_wait_timer (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd1);

endmodule

// File: rtl/z80_io_responder.sv
// rtl/z80_io_responder.sv - Z80 I/O bus target with register window, wait states and IM2 interrupt
// Purpose: answers CPU IN/OUT cycles at an aligned block of NREG ports, stretches
//          them with nWAIT, raises nINT on irq_req and returns an IM2 vector on
//          interrupt acknowledge.
// Ports:
//   clk, nRESET        CPU clock, synchronous active-low reset
//   A[15:0]            address bus (A[7:0] decoded)
//   D_in / D_out / D_oe data bus input, drive value, drive enable
//   nM1 nIORQ nRD nWR  CPU control strobes (active low)
//   nWAIT              0 = stretch current cycle
//   nINT               0 = interrupt requested
//   irq_req            1-clk user interrupt request pulse
//   reg_q[8*NREG-1:0]  flattened register contents, reg i at [8i+7:8i]
module z80_io_responder
  import z80_io_responder_pkg::*;
#(
  parameter logic [7:0] BASE_PORT   = 8'h40,
  parameter int         NREG        = 4,
  parameter int         WAIT_STATES = 2,
  parameter logic [7:0] IRQ_VEC     = 8'hE0,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic [15:0]       A,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  input  logic              nM1,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  output logic              nWAIT,
  output logic              nINT,
  input  logic              irq_req,
  output logic [8*NREG-1:0] reg_q
);

  localparam int         IDXW     = $clog2(NREG);
  localparam logic [7:0] WIN_MASK = ~8'(NREG - 1);
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_STATES);

  state_t          r_state;
  logic [7:0]      r_regs [NREG];
  logic [IDXW-1:0] r_idx;
  logic            r_wrote;
  logic            r_pending;
  logic            r_doe;
  logic [7:0]      r_dout;
  logic            r_nwait;
  logic            r_nint;

  logic [7:0]      w_port;
  logic            w_match;
  logic            w_io_start;
  logic            w_ack_start;
  logic            w_inta_clear;
  logic            w_tmr_load;
  logic            w_tmr_dec;
  logic            w_tmr_done;

  assign w_port      = port_of(A);
  assign w_match     = (w_port & WIN_MASK) == (BASE_PORT & WIN_MASK);
  assign w_io_start  = (nIORQ == PIN_ON) && (nM1 == PIN_OFF) && w_match;
  // Acknowledges while nothing is pending belong to another daisy-chain device.
  assign w_ack_start = (nIORQ == PIN_ON) && (nM1 == PIN_ON) && r_pending;
  assign w_inta_clear = (r_state == ST_INTA) && (nIORQ == PIN_OFF);

  assign w_tmr_load = (r_state == ST_IDLE) && w_io_start;
  assign w_tmr_dec  = (r_state == ST_WAIT);

  z80_wait_timer u_wait_timer (
    .clk       (clk),
    .nRESET    (nRESET),
    .i_load    (w_tmr_load),
    .i_load_val(WAIT_LD),
    .i_dec     (w_tmr_dec),
    .o_done    (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_wrote   <= 1'b0;
      r_pending <= 1'b0;
      r_doe     <= 1'b0;
      r_dout    <= 8'h00;
      r_nwait   <= 1'b1;
      r_nint    <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      // A request on the acknowledge-clearing edge wins so it is not lost.
      if (irq_req) begin
        r_pending <= 1'b1;
      end else if (w_inta_clear) begin
        r_pending <= 1'b0;
      end
      r_nint <= (w_inta_clear && !irq_req) ? 1'b1 : ~r_pending;

      case (r_state)
        ST_IDLE: begin
          r_doe <= 1'b0;
          if (w_io_start) begin
            // Latch the register index so address wobble mid-cycle is harmless.
            r_idx   <= w_port[IDXW-1:0];
            r_wrote <= 1'b0;
            if (WAIT_STATES > 0) begin
              r_state <= ST_WAIT;
              r_nwait <= 1'b0;
            end else begin
              r_state <= ST_ACT;
            end
          end else if (w_ack_start) begin
            r_state <= ST_INTA;
          end
        end

        ST_WAIT: begin
          if (nIORQ == PIN_OFF) begin
            r_state <= ST_IDLE;
            r_nwait <= 1'b1;
          end else if (w_tmr_done) begin
            r_state <= ST_ACT;
            r_nwait <= 1'b1;
          end
        end

        ST_ACT: begin
          if (nIORQ == PIN_OFF) begin
            r_state <= ST_IDLE;
            r_doe   <= 1'b0;
          end else if (nRD == PIN_ON) begin
            // Read has priority; a simultaneous nWR is a bus fault and is dropped.
            r_doe  <= 1'b1;
            r_dout <= r_regs[r_idx];
          end else if ((nWR == PIN_ON) && !r_wrote) begin
            r_regs[r_idx] <= D_in;
            r_wrote       <= 1'b1;
          end
        end

        ST_INTA: begin
          if (nIORQ == PIN_OFF) begin
            r_state <= ST_IDLE;
            r_doe   <= 1'b0;
          end else begin
            r_doe  <= 1'b1;
            r_dout <= inta_vector(IRQ_VEC);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regq
    assign reg_q[reg_lsb(g) +: 8] = r_regs[g];
  end

  assign D_out = r_dout;
  assign D_oe  = r_doe;
  assign nWAIT = r_nwait;
  assign nINT  = r_nint;

endmodule

// File: tb/tb_z80_io_responder.sv
// tb/tb_z80_io_responder.sv - scoreboard testbench for z80_io_responder
module tb_z80_io_responder;

  localparam int WAIT_N = 2;

  logic        clk = 1'b0;
  logic        nRESET;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;
  logic        nM1, nIORQ, nRD, nWR;
  logic        nWAIT, nINT;
  logic        irq_req;
  logic [31:0] reg_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model [4];
  int         wait_q [$];
  logic [7:0] data_q [$];

  z80_io_responder #(
    .BASE_PORT  (8'h40),
    .NREG       (4),
    .WAIT_STATES(WAIT_N),
    .IRQ_VEC    (8'hE1),
    .RESET_VAL  (8'h00)
  ) dut (
    .clk    (clk),
    .nRESET (nRESET),
    .A      (A),
    .D_in   (D_in),
    .D_out  (D_out),
    .D_oe   (D_oe),
    .nM1    (nM1),
    .nIORQ  (nIORQ),
    .nRD    (nRD),
    .nWR    (nWR),
    .nWAIT  (nWAIT),
    .nINT   (nINT),
    .irq_req(irq_req),
    .reg_q  (reg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_regq();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = model[i];
    return v;
  endfunction

  // Monitor: every D_oe rise must match the next queued drive value, and every
  // nWAIT low run must match the next queued wait length.
  initial begin
    logic prev_oe;
    int   run;
    logic [7:0] exp_d;
    int   exp_w;
    prev_oe = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (D_oe === 1'b1 && prev_oe !== 1'b1) begin
        if (data_q.size() == 0) begin
          check("drive_unexpected", {24'h0, D_out}, 32'hFFFF_FFFF);
        end else begin
          exp_d = data_q.pop_front();
          check("drive_data", {24'h0, D_out}, {24'h0, exp_d});
        end
      end
      prev_oe = D_oe;
      if (nWAIT === 1'b0) begin
        run++;
      end else if (run != 0) begin
        if (wait_q.size() == 0) begin
          check("wait_unexpected", run, 0);
        end else begin
          exp_w = wait_q.pop_front();
          check("wait_len", run, exp_w);
        end
        run = 0;
      end
    end
  end

  task automatic idle_bus();
    A = 16'h0000; D_in = 8'h00;
    nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
    logic hit;
    hit = ((addr[7:0] & 8'hFC) == 8'h40);
    if (hit) wait_q.push_back(WAIT_N);
    A = addr; D_in = data; nM1 = 1'b1; nRD = 1'b1; nIORQ = 1'b0; nWR = 1'b0;
    @(posedge clk); #1 A = addr ^ 16'h0001;
    repeat (4) @(posedge clk);
    #1 D_in = ~data;
    @(posedge clk); #1 nIORQ = 1'b1; nWR = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (hit) model[addr[1:0]] = data;
  endtask

  task automatic io_read(input logic [15:0] addr, input logic [7:0] exp);
    wait_q.push_back(WAIT_N);
    data_q.push_back(exp);
    A = addr; nM1 = 1'b1; nWR = 1'b1; nIORQ = 1'b0; nRD = 1'b0;
    @(posedge clk); #1 A = addr ^ 16'h0002;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("read_oe_held", D_oe, 1'b1);
    check("read_data_held", D_out, exp);
    @(posedge clk); #1 nIORQ = 1'b1; nRD = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("read_oe_release", D_oe, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic irq_pulse();
    irq_req = 1'b1;
    @(posedge clk); #1 irq_req = 1'b0;
    @(negedge clk);
    check("nint_not_yet", nINT, 1'b1);
    @(negedge clk);
    check("nint_low", nINT, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic int_ack(input logic irq_at_clear);
    data_q.push_back(8'hE0);
    nM1 = 1'b0; nIORQ = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("inta_vector", {D_oe, D_out}, {1'b1, 8'hE0});
    @(posedge clk); #1 nIORQ = 1'b1; nM1 = 1'b1; irq_req = irq_at_clear;
    @(posedge clk); #1 irq_req = 1'b0;
    @(negedge clk);
    check("inta_oe_release", D_oe, 1'b0);
    check("inta_nint_after", nINT, irq_at_clear ? 1'b0 : 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    idle_bus();
    irq_req = 1'b0;
    nRESET  = 1'b0;

    // Reset held two clocks.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_regq", reg_q, 32'h0);
    check("reset_nwait", nWAIT, 1'b1);
    check("reset_nint", nINT, 1'b1);
    check("reset_doe", D_oe, 1'b0);
    @(posedge clk); #1 nRESET = 1'b1;
    @(posedge clk); #1;

    // Writes: window hit, aliased high byte, then outside the window.
    io_write(16'h0042, 8'hA5);
    check("wr42_regq", reg_q, model_regq());
    io_write(16'hFF43, 8'h3C);
    check("wr43_regq", reg_q, model_regq());
    io_write(16'h0050, 8'h11);
    check("wr50_regq", reg_q, model_regq());
    io_write(16'h0044, 8'h99);
    check("wr44_regq", reg_q, model_regq());

    // Reads back.
    io_read(16'h0042, 8'hA5);
    io_read(16'h1243, 8'h3C);
    io_read(16'h0040, 8'h00);
    check("after_reads_regq", reg_q, model_regq());

    // Acknowledge while nothing is pending is ignored.
    nM1 = 1'b0; nIORQ = 1'b0;
    repeat (3) @(posedge clk);
    #1 nM1 = 1'b1; nIORQ = 1'b1;
    @(posedge clk); #1;
    check("stray_ack_nint", nINT, 1'b1);

    // Interrupt, acknowledge, clear.
    irq_pulse();
    int_ack(1'b0);
    // Merged requests, then a request on the clearing edge keeps nINT low.
    irq_pulse();
    irq_req = 1'b1;
    @(posedge clk); #1 irq_req = 1'b0;
    @(posedge clk); #1;
    int_ack(1'b1);
    int_ack(1'b0);

    // Reset during the wait of a write to 0x41.
    wait_q.push_back(1);
    A = 16'h0041; D_in = 8'h77; nM1 = 1'b1; nRD = 1'b1; nIORQ = 1'b0; nWR = 1'b0;
    @(posedge clk); #1 nRESET = 1'b0; nIORQ = 1'b1; nWR = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_nwait", nWAIT, 1'b1);
    check("rst_wait_regq", reg_q, model_regq());
    #1 nRESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wait_reg1", reg_q, model_regq());

    // Restart from IDLE works normally.
    io_write(16'h0041, 8'h5A);
    check("restart_regq", reg_q, model_regq());
    io_read(16'h0041, 8'h5A);

    repeat (4) @(posedge clk);
    check("wait_q_drained", wait_q.size(), 0);
    check("data_q_drained", data_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
